// File: rtl/matrix_reader.sv
// Streams a MATRIX_DIM x MATRIX_DIM matrix from matrix storage onto a valid/ready stream.
// Optional column-major readout is enabled by defining MATRIX_READER_TRANSPOSE_EN.
module matrix_reader #(
  parameter int MATRIX_DIM = 16,
  parameter int DATA_W     = 16,
  parameter int LENGTH     = MATRIX_DIM * MATRIX_DIM,
  localparam int CNT_W     = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1,
  localparam int ADDR_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef MATRIX_READER_TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef logic [DATA_W-1:0] data_t;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MATRIX_DIM - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  row_q, col_q;
  logic [CNT_W-1:0]  row_d, col_d;
  data_t             out_data_q;
  logic              out_valid_q, out_last_q, done_q;
  logic              is_last, load_en;

  // Address products are formed at 32 bits and then narrowed, so no DIM can overflow them.
`ifdef MATRIX_READER_TRANSPOSE_EN
  logic transpose_q;
  assign mem_addr = transpose_q ? ADDR_W'(int'(col_q) * MATRIX_DIM + int'(row_q))
                                : ADDR_W'(int'(row_q) * MATRIX_DIM + int'(col_q));
`else
  assign mem_addr = ADDR_W'(int'(row_q) * MATRIX_DIM + int'(col_q));
`endif

  assign is_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign load_en = (state_q == STREAM) && (!out_valid_q || out_ready);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_q == LAST_IDX) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef MATRIX_READER_TRANSPOSE_EN
      transpose_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= STREAM;
`ifdef MATRIX_READER_TRANSPOSE_EN
            transpose_q <= transpose;
`endif
          end
        end
        STREAM: begin
          // A new element is loaded whenever the output register is empty or being drained.
          if (load_en) begin
            out_data_q  <= mem_q;
            out_valid_q <= 1'b1;
            out_last_q  <= is_last;
            if (is_last) begin
              state_q <= DRAIN;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            row_q       <= '0;
            col_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_matrix_reader.sv
// Directed self-checking bench for matrix_reader: a DIM=4 instance with storage
// preloaded to data[i]=i, plus a DIM=1 instance for the single-beat boundary.
module tb_matrix_reader;

  localparam int DIM = 4;
  localparam int LEN = DIM * DIM;
  localparam int DW  = 8;
  localparam int AW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, outReady;
  logic          busy, done, outValid, outLast;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memQ, outData;
  logic [DW-1:0] storage [LEN];
`ifdef MATRIX_READER_TRANSPOSE_EN
  logic          transpose, transpose1;
`endif

  logic          start1, outReady1, busy1, done1, outValid1, outLast1;
  logic [0:0]    memAddr1;
  logic [DW-1:0] memQ1, outData1;

  int testsRun = 0;
  int testsFailed = 0;

  assign memQ  = storage[memAddr];
  assign memQ1 = 8'h5A;

  matrix_reader #(.MATRIX_DIM(DIM), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MATRIX_READER_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .busy(busy), .done(done), .mem_addr(memAddr), .mem_q(memQ),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady), .out_last(outLast)
  );

  matrix_reader #(.MATRIX_DIM(1), .DATA_W(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef MATRIX_READER_TRANSPOSE_EN
    .transpose(transpose1),
`endif
    .busy(busy1), .done(done1), .mem_addr(memAddr1), .mem_q(memQ1),
    .out_data(outData1), .out_valid(outValid1), .out_ready(outReady1), .out_last(outLast1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic startV, input logic readyV);
    start    = startV;
    outReady = readyV;
  endtask

  function automatic int expVal(input int k, input bit tr);
    return tr ? (k % DIM) * DIM + k / DIM : k;
  endfunction

  // Pulse start, then confirm the first beat appears one edge after the accepting edge.
  task automatic startSeq(input string tag, input bit tr);
`ifdef MATRIX_READER_TRANSPOSE_EN
    transpose = tr;
`endif
    applyStimulus(1'b1, 1'b1);
    tick();
`ifdef MATRIX_READER_TRANSPOSE_EN
    transpose = ~tr;
`endif
    applyStimulus(1'b0, 1'b1);
    checkOutput({tag, "_validAfterStart"}, 32'(outValid), 32'd0);
    checkOutput({tag, "_busyAfterStart"}, 32'(busy), 32'd1);
    tick();
    checkOutput({tag, "_firstValid"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_firstData"}, 32'(outData), 32'(expVal(0, tr)));
  endtask

  // Consumes the whole stream, checking order, out_last, stalls and the done pulse.
  task automatic runStream(input string tag, input int stallBeat, input bit randomReady,
                           input bit pulseMid, input bit tr, input int expCycles);
    int  idx = 0;
    int  cycles = 0;
    int  stalls = 0;
    int  doneEarly = 0;
    bit  pulsed = 1'b0;
    bit  rdy;
    bit  st;
    while (idx < LEN && cycles < 400) begin
      rdy = 1'b1;
      if (outValid && idx == stallBeat && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
        checkOutput({tag, "_heldData"}, 32'(outData), 32'(expVal(idx, tr)));
        checkOutput({tag, "_heldLast"}, 32'(outLast), 32'd0);
      end else if (randomReady && idx > stallBeat) begin
        rdy = 1'($urandom_range(0, 1));
      end
      st = pulseMid && idx == 5 && !pulsed;
      if (st) pulsed = 1'b1;
      applyStimulus(st, rdy);
      if (done) doneEarly++;
      if (outValid && rdy) begin
        checkOutput({tag, "_data"}, 32'(outData), 32'(expVal(idx, tr)));
        checkOutput({tag, "_last"}, 32'(outLast), 32'(idx == LEN - 1));
        idx++;
      end
      tick();
      cycles++;
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput({tag, "_beats"}, 32'(idx), 32'(LEN));
    if (expCycles > 0) checkOutput({tag, "_cycles"}, 32'(cycles), 32'(expCycles));
    checkOutput({tag, "_noEarlyDone"}, 32'(doneEarly), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busyAtDone"}, 32'(busy), 32'd0);
    checkOutput({tag, "_validAtDone"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < LEN; i++) storage[i] = DW'(i);
    rst_n = 1'b0;
    start1 = 1'b0;
    outReady1 = 1'b1;
`ifdef MATRIX_READER_TRANSPOSE_EN
    transpose = 1'b0;
    transpose1 = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_data", 32'(outData), 32'd0);
    checkOutput("rst_last", 32'(outLast), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_valid", 32'(outValid), 32'd0);

    // Full stream with out_ready held high.
    startSeq("full", 1'b0);
    runStream("full", -1, 1'b0, 1'b0, 1'b0, LEN);
    tick();
    checkOutput("full_doneOneCycle", 32'(done), 32'd0);

    // Three-cycle stall on beat 5, then random backpressure.
    startSeq("bp", 1'b0);
    runStream("bp", 5, 1'b1, 1'b0, 1'b0, 0);
    tick();
    checkOutput("bp_doneOneCycle", 32'(done), 32'd0);

    // start mid-stream is ignored; start in the done cycle begins a new sequence.
    startSeq("ign", 1'b0);
    runStream("ign", -1, 1'b0, 1'b1, 1'b0, LEN);
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1);
    checkOutput("b2b_doneLow", 32'(done), 32'd0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_validAfterStart", 32'(outValid), 32'd0);
    tick();
    checkOutput("b2b_firstValid", 32'(outValid), 32'd1);
    checkOutput("b2b_firstData", 32'(outData), 32'd0);
    runStream("b2b", -1, 1'b0, 1'b0, 1'b0, LEN);
    tick();

    // Reset after beat 7 aborts the stream without a done pulse.
    startSeq("mid", 1'b0);
    repeat (8) tick();
    checkOutput("mid_beforeReset", 32'(outData), 32'd8);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_valid", 32'(outValid), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_done", 32'(done), 32'd0);
    checkOutput("mid_addr", 32'(memAddr), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_doneAfter", 32'(done), 32'd0);
    startSeq("restart", 1'b0);
    runStream("restart", -1, 1'b0, 1'b0, 1'b0, LEN);
    tick();

`ifdef MATRIX_READER_TRANSPOSE_EN
    // Column-major readout; transpose is flipped after start to prove it is latched.
    startSeq("tr", 1'b1);
    runStream("tr", -1, 1'b0, 1'b0, 1'b1, LEN);
    tick();
`endif

    // DIM=1: one beat carrying out_last, done two edges after the accepting edge.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("dim1_validAfterStart", 32'(outValid1), 32'd0);
    checkOutput("dim1_busy", 32'(busy1), 32'd1);
    checkOutput("dim1_addr", 32'(memAddr1), 32'd0);
    tick();
    checkOutput("dim1_valid", 32'(outValid1), 32'd1);
    checkOutput("dim1_data", 32'(outData1), 32'h5A);
    checkOutput("dim1_last", 32'(outLast1), 32'd1);
    checkOutput("dim1_doneEarly", 32'(done1), 32'd0);
    tick();
    checkOutput("dim1_done", 32'(done1), 32'd1);
    checkOutput("dim1_validAfter", 32'(outValid1), 32'd0);
    checkOutput("dim1_busyAfter", 32'(busy1), 32'd0);
    tick();
    checkOutput("dim1_doneOneCycle", 32'(done1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/matrix_reader.md
Name: matrix_reader

Overview:
- Streams a stored MATRIX_DIM x MATRIX_DIM matrix out of the TPU's matrix storage block.
- Drives that block's address port (combinational read data returned on mem_q) and emits one element per beat on a valid/ready stream towards the systolic array / output path.
- Read-side counterpart of the storage write port; one read sequence per start pulse.

Parameters:
- MATRIX_DIM, 16, rows = columns of the matrix
- LENGTH, MATRIX_DIM*MATRIX_DIM, total elements per matrix

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin a read sequence; honoured only in IDLE
- busy  output  1  high in any state other than IDLE
- done  output  1  single-cycle pulse after the final element handshake
- mem_addr  output  $clog2(LENGTH)  read address to matrix storage
- mem_q  input  data_t  combinational read data for mem_addr
- out_data  output  data_t  streamed element, registered
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_last  output  1  qualifies final element (with out_valid)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, row=col=0, out_data=0, out_valid=0, out_last=0, done=0, busy=0, mem_addr=0. Reset mid-stream aborts immediately; no done is pulsed.
- mem_addr = row*MATRIX_DIM + col (row-major); combinational from the counters.
- States:
  - IDLE: start=1 -> row=col=0, go to STREAM.
  - STREAM: load when (!out_valid || out_ready). A load does out_data<=mem_q, out_valid<=1, out_last<=(row==DIM-1 && col==DIM-1), then advances col. col wraps DIM-1->0 and increments row. If the loaded element is the last one, go to DRAIN and do not advance.
  - DRAIN: on out_valid&&out_ready -> out_valid<=0, out_last<=0, done<=1, go to IDLE.
- done is high for exactly one cycle and is otherwise 0.
- Handshake:
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on reset.
- Latency:
  - start sampled at edge N -> first out_valid after edge N+1.
  - With out_ready held high: one element per cycle, LENGTH beats, done pulse after the edge following the last handshake.
- start while busy is ignored (no restart, no queueing).
- start in the same cycle done is high: state is already IDLE, so it is accepted and a new sequence begins.
- out_ready may toggle arbitrarily. Beats are emitted in order with no duplicates or skips.
- Counters are sized $clog2(MATRIX_DIM) bits (minimum 1). Address arithmetic must not overflow for any DIM >= 1.
- DIM=1: single beat, out_last=1 on it.

Optional Feature:
- Macro: MATRIX_READER_TRANSPOSE_EN.
- Defined:
  - Adds input port transpose (1 bit), sampled only when start is accepted and latched for the whole sequence.
  - transpose=1 gives mem_addr = col*MATRIX_DIM + row, i.e. the matrix is streamed column-major.
  - Beat order, out_last and done are unchanged.
- Undefined: port absent; always row-major.

Test Plan:
- Reset/idle: DIM=4, storage preloaded with data[i]=i, rst_n=0 then 1 -> out_valid=0, busy=0, done=0, mem_addr=0.
- Full stream: DIM=4, start pulse at cycle N, out_ready=1 ->
  - out_valid from cycle N+2, out_data 0,1,...,15 on consecutive cycles
  - out_last only on value 15
  - done pulse in cycle N+18, busy falls in the same cycle
- Backpressure: same setup, out_ready low for 3 cycles on beat 5 and random 50% thereafter -> value 5 held stable for the stalled cycles; received sequence still exactly 0..15; done once.
- start ignored/back-to-back: start re-pulsed mid-stream -> no effect. start pulsed the cycle done is high -> second full 0..15 sequence, first beat 2 cycles later.
- Reset mid-operation: rst_n=0 after beat 7 -> next cycle out_valid=0, busy=0, no done. A later start restarts from value 0.
- Transpose (MATRIX_READER_TRANSPOSE_EN defined): DIM=4, transpose=1 at start -> out_data 0,4,8,12,1,5,...,15, out_last on 15. DIM=1 build -> single beat, out_last=1, done 2 cycles after start.
